// File: rtl/wisc_isa_pkg.sv
// rtl/wisc_isa_pkg.sv - WISC opcodes, field positions, fetch FSM states and source-hazard helper
package wisc_isa_pkg;

    localparam logic [15:0] NOP_INST_DEF = 16'h0800;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 5;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ADD   = 5'b11011;
    localparam logic [4:0] OP_SHIFT = 5'b11010;

    // Opcode-group prefixes (top three opcode bits)
    localparam logic [2:0] PFX_CMP  = 3'b111;
    localparam logic [2:0] PFX_JMP  = 3'b001;
    localparam logic [2:0] PFX_BR   = 3'b011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic src_conflict(
        input logic       wrt,
        input logic [2:0] wreg,
        input logic       use_rs,
        input logic       use_rt,
        input logic [2:0] rs,
        input logic [2:0] rt
    );
        return wrt & ((use_rs & (wreg == rs)) | (use_rt & (wreg == rt)));
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: instruction word, stage writers, PC/F-D controls
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [15:0]      fetchInst;
    logic             createDump;
    logic             regWrtD;
    logic             regWrtX;
    logic             regWrtM;
    logic [2:0]       wrtRegD;
    logic [2:0]       wrtRegX;
    logic [2:0]       wrtRegM;
    logic             brResolve;
    logic             pcWrtEn;
    logic [15:0]      instOut;
    logic             instValid;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output fetchInst, createDump, regWrtD, regWrtX, regWrtM,
               wrtRegD, wrtRegX, wrtRegM, brResolve,
        input  pcWrtEn, instOut, instValid, halted, err, stallCnt, flushCnt
    );

    modport slave (
        input  fetchInst, createDump, regWrtD, regWrtX, regWrtM,
               wrtRegD, wrtRegX, wrtRegM, brResolve,
        output pcWrtEn, instOut, instValid, halted, err, stallCnt, flushCnt
    );
endinterface

// File: rtl/wisc_src_decode.sv
// rtl/wisc_src_decode.sv - source-operand usage and control-class decode of a WISC word
module wisc_src_decode
    import wisc_isa_pkg::*;
(
    input  logic [OPC_MSB:RT_LSB] inst_i,
    output logic                  use_rs_o,
    output logic                  use_rt_o,
    output logic                  is_ctl_o,
    output logic                  is_halt_o,
    output logic [2:0]            rs_o,
    output logic [2:0]            rt_o
);
    logic [4:0] opc;

    assign opc  = inst_i[OPC_MSB:OPC_LSB];
    assign rs_o = inst_i[RS_MSB:RS_LSB];
    assign rt_o = inst_i[RT_MSB:RT_LSB];

    always_comb begin
        use_rs_o = 1'b1;
        case (opc)
            OP_HALT, OP_NOP, OP_SIIC, OP_RTI, OP_J, OP_JAL, OP_LBI: use_rs_o = 1'b0;
            default:                                                use_rs_o = 1'b1;
        endcase
    end

    assign use_rt_o  = (opc == OP_ADD) | (opc == OP_SHIFT) | (opc[4:2] == PFX_CMP)
                     | (opc == OP_ST)  | (opc == OP_STU);
    assign is_ctl_o  = (opc[4:2] == PFX_JMP) | (opc[4:2] == PFX_BR);
    assign is_halt_o = (opc == OP_HALT);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencing: RAW stalls, branch flush with timeout, HALT, dump freeze
// Optional perf counters under FETCH_PERF_EN.
module fetch_ctrl
    import wisc_isa_pkg::*;
#(
    parameter logic [15:0] NOP_INST   = NOP_INST_DEF,
    parameter int          BR_TIMEOUT = 4,
    parameter int          CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);
    localparam int             TMR_W   = $clog2(BR_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BR_TIMEOUT);

    fetch_state_e     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    logic       use_rs, use_rt, is_ctl, is_halt;
    logic [2:0] rs, rt;
    logic       hazard;
    logic       pc_wrt_en, inst_valid, halted;
    logic [15:0] inst_out;

    wisc_src_decode u_decode (
        .inst_i    (bus.fetchInst[OPC_MSB:RT_LSB]),
        .use_rs_o  (use_rs),
        .use_rt_o  (use_rt),
        .is_ctl_o  (is_ctl),
        .is_halt_o (is_halt),
        .rs_o      (rs),
        .rt_o      (rt)
    );

    // W-stage writers are bypassed by the register file, so only D/X/M matter
    assign hazard = src_conflict(bus.regWrtD, bus.wrtRegD, use_rs, use_rt, rs, rt)
                  | src_conflict(bus.regWrtX, bus.wrtRegX, use_rs, use_rt, rs, rt)
                  | src_conflict(bus.regWrtM, bus.wrtRegM, use_rs, use_rt, rs, rt);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        err_d      = err_q;
        pc_wrt_en  = 1'b0;
        inst_out   = NOP_INST;
        inst_valid = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state_q)
                HALT: halted = 1'b1;
                FLUSH: begin
                    if (!bus.createDump) begin
                        timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
                        if (bus.brResolve) begin
                            pc_wrt_en = 1'b1;
                            state_d   = RUN;
                        end else if (timer_d == TMR_MAX) begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.createDump && !hazard) begin
                        inst_out   = bus.fetchInst;
                        inst_valid = 1'b1;
                        if (is_halt) begin
                            state_d = HALT;
                        end else begin
                            pc_wrt_en = 1'b1;
                            if (is_ctl) begin
                                state_d = FLUSH;
                                timer_d = '0;
                            end
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.pcWrtEn   = pc_wrt_en;
    assign bus.instOut   = inst_out;
    assign bus.instValid = inst_valid;
    assign bus.halted    = halted;
    assign bus.err       = err_q & ~rst;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters; a dump-frozen FLUSH cycle is not a flush cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == RUN && hazard && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_q == FLUSH && !bus.createDump && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stallCnt = stall_cnt_q;
    assign bus.flushCnt = flush_cnt_q;
`else
    assign bus.stallCnt = '0;
    assign bus.flushCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [15:0] NOP  = 16'h0800;
    localparam logic [15:0] ADD  = 16'hD920;
    localparam logic [15:0] ADD2 = 16'hD940;
    localparam logic [15:0] BEQZ = 16'h6104;
    localparam logic [15:0] HLT  = 16'h0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_ctrl_if #(.CNT_W(16)) bus ();

    fetch_ctrl #(.NOP_INST(16'h0800), .BR_TIMEOUT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic out3(input string tag, input logic pc, input logic [15:0] inst, input logic vld);
        chk1({tag, "_pcWrtEn"}, bus.pcWrtEn, pc);
        chk16({tag, "_instOut"}, bus.instOut, inst);
        chk1({tag, "_instValid"}, bus.instValid, vld);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] pexp(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.fetchInst = ADD; bus.createDump = 1'b0; bus.brResolve = 1'b0;
        bus.regWrtD = 1'b0; bus.regWrtX = 1'b0; bus.regWrtM = 1'b0;
        bus.wrtRegD = 3'd0; bus.wrtRegX = 3'd0; bus.wrtRegM = 3'd0;
        nxt();
        #1;
        out3("reset", 1'b0, NOP, 1'b0);
        chk1("reset_halted", bus.halted, 1'b0);
        chk1("reset_err", bus.err, 1'b0);
        chk16("reset_stall", bus.stallCnt, 16'd0);
        chk16("reset_flush", bus.flushCnt, 16'd0);
        nxt();

        rst = 1'b0; #1;
        out3("add_pass", 1'b1, ADD, 1'b1);
        nxt();

        bus.regWrtX = 1'b1; bus.wrtRegX = 3'd1; #1;
        out3("raw_x_1", 1'b0, NOP, 1'b0);
        nxt(); #1;
        out3("raw_x_2", 1'b0, NOP, 1'b0);
        nxt();
        bus.regWrtX = 1'b0; #1;
        out3("raw_release", 1'b1, ADD, 1'b1);
        chk16("stall_cnt_2", bus.stallCnt, pexp(2));
        nxt();

        bus.regWrtX = 1'b1; bus.wrtRegX = 3'd2; #1;
        out3("x_other_reg", 1'b1, ADD, 1'b1);
        nxt();

        bus.regWrtX = 1'b0; bus.regWrtD = 1'b1; bus.wrtRegD = 3'd2; bus.fetchInst = ADD2; #1;
        out3("raw_d_rt", 1'b0, NOP, 1'b0);
        nxt();

        bus.regWrtD = 1'b0; bus.regWrtM = 1'b1; bus.wrtRegM = 3'd0; bus.fetchInst = NOP; #1;
        out3("nop_no_src", 1'b1, NOP, 1'b1);
        nxt();
        bus.regWrtM = 1'b0;

        bus.fetchInst = BEQZ; #1;
        out3("br_pass", 1'b1, BEQZ, 1'b1);
        nxt();
        bus.fetchInst = ADD; #1;
        out3("flush_1", 1'b0, NOP, 1'b0);
        nxt(); #1;
        out3("flush_2", 1'b0, NOP, 1'b0);
        nxt();
        bus.brResolve = 1'b1; bus.regWrtX = 1'b1; bus.wrtRegX = 3'd1; #1;
        out3("flush_resolve", 1'b1, NOP, 1'b0);
        chk16("flush_cnt_2", bus.flushCnt, pexp(2));
        nxt();
        bus.brResolve = 1'b0; #1;
        out3("post_redirect_raw", 1'b0, NOP, 1'b0);
        chk16("flush_cnt_3", bus.flushCnt, pexp(3));
        nxt();
        bus.regWrtX = 1'b0; #1;
        out3("post_redirect_pass", 1'b1, ADD, 1'b1);
        chk16("stall_cnt_4", bus.stallCnt, pexp(4));
        nxt();

        bus.fetchInst = BEQZ; #1;
        out3("br2_pass", 1'b1, BEQZ, 1'b1);
        nxt();
        bus.fetchInst = ADD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("timeout_err_low", bus.err, 1'b0);
            chk1("timeout_pc_low", bus.pcWrtEn, 1'b0);
            nxt();
        end
        #1;
        chk1("timeout_err_set", bus.err, 1'b1);
        out3("timeout_still_flush", 1'b0, NOP, 1'b0);
        nxt();
        bus.brResolve = 1'b1; #1;
        chk1("late_resolve_pc", bus.pcWrtEn, 1'b1);
        chk1("late_resolve_err", bus.err, 1'b1);
        nxt();
        bus.brResolve = 1'b0; #1;
        out3("after_timeout_run", 1'b1, ADD, 1'b1);
        chk1("err_sticky", bus.err, 1'b1);
        chk16("flush_cnt_9", bus.flushCnt, pexp(9));
        nxt();

        rst = 1'b1; #1;
        chk1("rst_mid_pc", bus.pcWrtEn, 1'b0);
        nxt();
        rst = 1'b0; #1;
        chk1("rst_err_clear", bus.err, 1'b0);
        chk16("rst_stall_clear", bus.stallCnt, 16'd0);
        chk16("rst_flush_clear", bus.flushCnt, 16'd0);
        out3("rst_resume", 1'b1, ADD, 1'b1);
        nxt();

        bus.fetchInst = HLT; #1;
        out3("halt_pass", 1'b0, HLT, 1'b1);
        chk1("halt_pass_halted", bus.halted, 1'b0);
        nxt();
        bus.fetchInst = ADD;
        for (int i = 0; i < 10; i++) begin
            bus.brResolve = (i % 2 == 0); #1;
            chk1("halt_halted", bus.halted, 1'b1);
            out3("halt_frozen", 1'b0, NOP, 1'b0);
            nxt();
        end
        bus.brResolve = 1'b0;
        rst = 1'b1; nxt();
        rst = 1'b0; #1;
        chk1("halt_exit_rst", bus.halted, 1'b0);

        bus.createDump = 1'b1; #1;
        out3("dump_run", 1'b0, NOP, 1'b0);
        nxt();
        bus.createDump = 1'b0; #1;
        out3("dump_release", 1'b1, ADD, 1'b1);
        nxt();
        bus.fetchInst = BEQZ; #1;
        out3("br3_pass", 1'b1, BEQZ, 1'b1);
        nxt();
        bus.createDump = 1'b1; bus.brResolve = 1'b1; bus.fetchInst = ADD; #1;
        out3("dump_flush", 1'b0, NOP, 1'b0);
        nxt();
        bus.createDump = 1'b0; #1;
        out3("dump_flush_resolve", 1'b1, NOP, 1'b0);
        nxt();
        bus.brResolve = 1'b0; #1;
        out3("dump_flush_run", 1'b1, ADD, 1'b1);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
